// File: rtl/cnt_display_mux_pkg.sv
// Shared constants and helpers for the count/lap seven-segment display.
package cnt_disp_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit position currently being refreshed; an[0] is the rightmost digit
  typedef enum logic [1:0] {
    DIG_CNT_ONES = 2'd0,
    DIG_CNT_TENS = 2'd1,
    DIG_LAP_ONES = 2'd2,
    DIG_LAP_TENS = 2'd3
  } digit_sel_e;

  // One BCD digit plus carry-in; returns {carry_out, digit}
  function automatic logic [4:0] bcd_inc(input bcd_t d, input logic cin);
    if (!cin) begin
      return {1'b0, d};
    end
    if (d >= 4'd9) begin
      return {1'b1, 4'd0};
    end
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/cnt_display_mux_seg7_enc.sv
// Combinational seven-segment encoder with dash and blank overrides.
module seg7_enc
  import cnt_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  // Dash wins over blank; codes above 9 render blank
  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/cnt_display_mux.sv
// Registers the 0..10 counter value, counts wraps as a BCD lap counter and
// multiplexes lap (left) and count (right) onto a 4-digit common-anode display.
module cnt_display_mux
  import cnt_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [7:0] lap_bcd,
  output logic       wrap_pulse,
  output logic       err
);

  localparam int unsigned     DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [3:0]       count_q;
  logic [7:0]       lap_q, lap_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [DIV_W-1:0] div_q, div_d;
  digit_sel_e       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [4:0]       ones_inc, tens_inc;
  logic [3:0]       enc_digit;
  logic             enc_blank, enc_dash;
  logic             count_over, count_ten;

  assign count_over = (count_q > 4'd10);
  assign count_ten  = (count_q == 4'd10);

  // Wrap detection, BCD lap increment and sticky error flag
  always_comb begin
    wrap_d   = count_ten && (count_in == 4'd0);
    ones_inc = bcd_inc(lap_q[3:0], wrap_d);
    tens_inc = bcd_inc(lap_q[7:4], ones_inc[4]);
    // carry out of the tens digit is dropped so 99 rolls over to 00
    lap_d    = 8'({tens_inc, ones_inc[3:0]});
    err_d    = err_q | (count_in > 4'd10);
  end

  // Refresh divider and digit-position advance
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    sel_d = sel_q;
    if (div_q == DIV_LAST) begin
      case (sel_q)
        DIG_CNT_ONES: sel_d = DIG_CNT_TENS;
        DIG_CNT_TENS: sel_d = DIG_LAP_ONES;
        DIG_LAP_ONES: sel_d = DIG_LAP_TENS;
        DIG_LAP_TENS: sel_d = DIG_CNT_ONES;
      endcase
    end
  end

  // Digit mux: select value, leading-zero blank and out-of-range dash
  always_comb begin
    enc_digit = '0;
    enc_blank = 1'b0;
    enc_dash  = 1'b0;
    an_d      = '1;
    case (sel_q)
      DIG_CNT_ONES: begin
        enc_digit = count_ten ? 4'd0 : count_q;
        enc_dash  = count_over;
        an_d      = 4'b1110;
      end
      DIG_CNT_TENS: begin
        enc_digit = count_ten ? 4'd1 : 4'd0;
        enc_blank = !count_ten;
        enc_dash  = count_over;
        an_d      = 4'b1101;
      end
      DIG_LAP_ONES: begin
        enc_digit = lap_q[3:0];
        an_d      = 4'b1011;
      end
      DIG_LAP_TENS: begin
        enc_digit = lap_q[7:4];
        an_d      = 4'b0111;
      end
    endcase
  end

  seg7_enc u_enc (
    .digit_i (enc_digit),
    .blank_i (enc_blank),
    .dash_i  (enc_dash),
    .seg_o   (seg_d)
  );

  // All state and registered outputs, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      div_q   <= '0;
      sel_q   <= DIG_CNT_ONES;
      an_q    <= '1;
      seg_q   <= '1;
    end else begin
      count_q <= count_in;
      lap_q   <= lap_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign lap_bcd    = lap_q;
  assign wrap_pulse = wrap_q;
  assign err        = err_q;

endmodule
